alu_decode_stage: RTL and testbench



---
 rtl/alu_pkg.sv | 53 +++++
 rtl/alu_decode_stage_if.sv | 44 ++++
 rtl/alu_decode_comb.sv | 134 +++++++++++++
 rtl/alu_decode_stage.sv | 113 +++++++++++
 tb/tb_alu_decode_stage.sv | 340 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared types for the ALU decode stage: op codes, RV32I opcodes and the
// decoded control word carried through the output and skid registers.
package alu_pkg;

  localparam int XLEN = 32;
  localparam int OP_W = 4;

  // ALU operation codes consumed by the ALU; ALU_SLA is reserved and never produced.
  typedef enum logic [OP_W-1:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_SLL = 4'd2,
    ALU_SLA = 4'd3,
    ALU_SRL = 4'd4,
    ALU_SRA = 4'd5,
    ALU_XOR = 4'd6,
    ALU_OR  = 4'd7,
    ALU_AND = 4'd8,
    ALU_BEQ = 4'd9,
    ALU_BNE = 4'd10,
    ALU_BLT = 4'd11,
    ALU_BGE = 4'd12,
    ALU_SLT = 4'd13
  } alu_op_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    alu_op_e         alu_op;
    logic [4:0]      shamt;
    logic            shamt_reg;
    logic            use_imm;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            reg_write;
    logic            is_branch;
    logic            illegal;
  } dec_word_t;

endpackage

// File: rtl/alu_decode_stage_if.sv
// Instruction-in / decoded-word-out bus of the ALU decode stage.
//
// Handshake: a word moves across a side on a rising clk edge where its
// valid and ready are both high. A producer holding valid keeps its data
// stable until that transfer; ready may be high without valid and never
// depends combinationally on valid.
interface alu_decode_stage_if;
  import alu_pkg::*;

  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_instr;

  logic            out_valid;
  logic            out_ready;
  logic [OP_W-1:0] out_alu_op;
  logic [4:0]      out_shamt;
  logic            out_shamt_reg;
  logic            out_use_imm;
  logic [XLEN-1:0] out_imm;
  logic [4:0]      out_rs1;
  logic [4:0]      out_rs2;
  logic [4:0]      out_rd;
  logic            out_reg_write;
  logic            out_is_branch;
  logic            out_illegal;

  // The decode stage: accepts instruction words, produces decoded words.
  modport master (
    input  in_valid, in_instr, out_ready,
    output in_ready, out_valid, out_alu_op, out_shamt, out_shamt_reg,
           out_use_imm, out_imm, out_rs1, out_rs2, out_rd,
           out_reg_write, out_is_branch, out_illegal
  );

  // Fetch on the input side and ALU stage on the output side.
  modport slave (
    output in_valid, in_instr, out_ready,
    input  in_ready, out_valid, out_alu_op, out_shamt, out_shamt_reg,
           out_use_imm, out_imm, out_rs1, out_rs2, out_rd,
           out_reg_write, out_is_branch, out_illegal
  );

endinterface

// File: rtl/alu_decode_comb.sv
// Pure combinational RV32I decoder: instruction word -> ALU control word.
// Illegal words collapse to a harmless add with no register write; the raw
// rs1/rs2/rd fields are always passed through.
module alu_decode_comb
  import alu_pkg::*;
(
  input  logic [XLEN-1:0] instr,
  output dec_word_t       dec
);

  logic [6:0]      opcode;
  logic [2:0]      f3;
  logic [6:0]      f7;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_s;
  logic [XLEN-1:0] imm_b;
  logic [XLEN-1:0] imm_u;
  logic [XLEN-1:0] imm_j;
  logic            ill;

  assign opcode = instr[6:0];
  assign f3     = instr[14:12];
  assign f7     = instr[31:25];

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  // Opcode/funct decode into the control word, then squash illegal encodings.
  always_comb begin
    dec        = '0;
    dec.alu_op = ALU_ADD;
    dec.rs1    = instr[19:15];
    dec.rs2    = instr[24:20];
    dec.rd     = instr[11:7];
    ill        = 1'b0;
    case (opcode)
      OPC_OP: begin
        dec.reg_write = 1'b1;
        if (f7 == F7_BASE) begin
          case (f3)
            3'b000:  dec.alu_op = ALU_ADD;
            3'b001:  begin dec.alu_op = ALU_SLL; dec.shamt_reg = 1'b1; end
            3'b010:  dec.alu_op = ALU_SLT;
            3'b100:  dec.alu_op = ALU_XOR;
            3'b101:  begin dec.alu_op = ALU_SRL; dec.shamt_reg = 1'b1; end
            3'b110:  dec.alu_op = ALU_OR;
            3'b111:  dec.alu_op = ALU_AND;
            default: ill = 1'b1;  // sltu is not supported by this ALU
          endcase
        end else if (f7 == F7_ALT && f3 == 3'b000) begin
          dec.alu_op = ALU_SUB;
        end else if (f7 == F7_ALT && f3 == 3'b101) begin
          dec.alu_op    = ALU_SRA;
          dec.shamt_reg = 1'b1;
        end else begin
          ill = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        dec.reg_write = 1'b1;
        dec.use_imm   = 1'b1;
        dec.imm       = imm_i;
        case (f3)
          3'b000: dec.alu_op = ALU_ADD;
          3'b010: dec.alu_op = ALU_SLT;
          3'b100: dec.alu_op = ALU_XOR;
          3'b110: dec.alu_op = ALU_OR;
          3'b111: dec.alu_op = ALU_AND;
          3'b001: begin
            if (f7 == F7_BASE) begin
              dec.alu_op = ALU_SLL;
              dec.shamt  = instr[24:20];
            end else begin
              ill = 1'b1;
            end
          end
          3'b101: begin
            dec.shamt = instr[24:20];
            if (f7 == F7_BASE) dec.alu_op = ALU_SRL;
            else if (f7 == F7_ALT) dec.alu_op = ALU_SRA;
            else ill = 1'b1;
          end
          default: ill = 1'b1;  // sltiu
        endcase
      end
      OPC_BRANCH: begin
        dec.is_branch = 1'b1;
        dec.imm       = imm_b;
        case (f3)
          3'b000:  dec.alu_op = ALU_BEQ;
          3'b001:  dec.alu_op = ALU_BNE;
          3'b100:  dec.alu_op = ALU_BLT;
          3'b101:  dec.alu_op = ALU_BGE;
          default: ill = 1'b1;
        endcase
      end
      OPC_LOAD, OPC_JALR: begin
        dec.reg_write = 1'b1;
        dec.use_imm   = 1'b1;
        dec.imm       = imm_i;
      end
      OPC_STORE: begin
        dec.use_imm = 1'b1;
        dec.imm     = imm_s;
      end
      OPC_LUI, OPC_AUIPC: begin
        dec.reg_write = 1'b1;
        dec.use_imm   = 1'b1;
        dec.imm       = imm_u;
      end
      OPC_JAL: begin
        dec.reg_write = 1'b1;
        dec.use_imm   = 1'b1;
        dec.imm       = imm_j;
      end
      default: ill = 1'b1;
    endcase

    if (ill) begin
      dec.alu_op    = ALU_ADD;
      dec.shamt     = 5'd0;
      dec.shamt_reg = 1'b0;
      dec.use_imm   = 1'b0;
      dec.imm       = '0;
      dec.reg_write = 1'b0;
      dec.is_branch = 1'b0;
      dec.illegal   = 1'b1;
    end
  end

endmodule

// File: rtl/alu_decode_stage.sv
// Registered ALU decode stage: one output register plus one skid entry so
// that in_ready is a flop. Words leave in the order they were accepted.
module alu_decode_stage
  import alu_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  alu_decode_stage_if.master  bus,
  output logic [CNT_W-1:0]    illegal_count
);

  dec_word_t        dec_in;
  dec_word_t        out_word;
  dec_word_t        skid_word;
  logic             out_valid_q;
  logic             skid_valid_q;
  logic             in_ready_q;
  logic [CNT_W-1:0] cnt_q;

  logic             in_xfer;
  logic             out_xfer;
  logic             load_out;
  logic             out_valid_d;
  logic             skid_valid_d;
  logic             out_load;
  logic             out_from_skid;
  logic             skid_load;
  logic             cnt_inc;

  alu_decode_comb u_decode (
    .instr (bus.in_instr),
    .dec   (dec_in)
  );

  assign in_xfer  = bus.in_valid && in_ready_q;
  assign out_xfer = out_valid_q && bus.out_ready;
  assign load_out = !out_valid_q || out_xfer;
  assign cnt_inc  = out_xfer && out_word.illegal && (cnt_q != {CNT_W{1'b1}});

  // Steer the incoming/skid word: output register first, skid when stalled.
  always_comb begin
    out_valid_d   = out_valid_q;
    skid_valid_d  = skid_valid_q;
    out_load      = 1'b0;
    out_from_skid = 1'b0;
    skid_load     = 1'b0;
    if (load_out) begin
      if (skid_valid_q) begin
        out_load      = 1'b1;
        out_from_skid = 1'b1;
        out_valid_d   = 1'b1;
        skid_valid_d  = 1'b0;
      end else if (in_xfer) begin
        out_load    = 1'b1;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (in_xfer) begin
      skid_load    = 1'b1;
      skid_valid_d = 1'b1;
    end
  end

  // Occupancy flags, registered in_ready and the saturating illegal counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b0;
      cnt_q        <= '0;
    end else if (flush) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= !skid_valid_d;
      if (cnt_inc) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Decoded-word datapath; contents are left alone by flush since valid drops.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_word  <= '0;
      skid_word <= '0;
    end else if (!flush) begin
      if (out_load)  out_word  <= out_from_skid ? skid_word : dec_in;
      if (skid_load) skid_word <= dec_in;
    end
  end

  assign bus.in_ready      = in_ready_q;
  assign bus.out_valid     = out_valid_q;
  assign bus.out_alu_op    = out_word.alu_op;
  assign bus.out_shamt     = out_word.shamt;
  assign bus.out_shamt_reg = out_word.shamt_reg;
  assign bus.out_use_imm   = out_word.use_imm;
  assign bus.out_imm       = out_word.imm;
  assign bus.out_rs1       = out_word.rs1;
  assign bus.out_rs2       = out_word.rs2;
  assign bus.out_rd        = out_word.rd;
  assign bus.out_reg_write = out_word.reg_write;
  assign bus.out_is_branch = out_word.is_branch;
  assign bus.out_illegal   = out_word.illegal;
  assign illegal_count     = cnt_q;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Bench for alu_decode_stage: an ISA mask/match table model feeds an
// expected queue; a negedge compare process checks every cycle.
module tb_alu_decode_stage;

  localparam int CNT_W   = 3;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  localparam int FMT_R = 0;
  localparam int FMT_I = 1;
  localparam int FMT_S = 2;
  localparam int FMT_B = 3;
  localparam int FMT_U = 4;
  localparam int FMT_J = 5;

  typedef struct {
    logic [31:0] mask;
    logic [31:0] match;
    int          op;
    int          fmt;
    bit          wr;
    bit          sreg;
    bit          shimm;
  } rule_t;

  // ---------------- clock / reset ----------------
  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             flush = 1'b0;
  logic [CNT_W-1:0] illegal_count;

  always #5 clk = ~clk;

  alu_decode_stage_if bus ();

  alu_decode_stage #(.CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .bus           (bus),
    .illegal_count (illegal_count)
  );

  // ---------------- bookkeeping ----------------
  int          checks = 0;
  int          failures = 0;
  logic [60:0] exp_q[$];
  rule_t       rules[$];
  int          model_cnt = 0;
  bit          model_rst_q = 1'b1;
  bit          held = 1'b0;
  logic [60:0] held_word;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [60:0] pack(input logic [3:0] op, input logic [4:0] sh,
                                       input logic sreg, input logic uimm,
                                       input logic [31:0] imm, input logic [4:0] rs1,
                                       input logic [4:0] rs2, input logic [4:0] rd,
                                       input logic wr, input logic br, input logic ill);
    return {op, sh, sreg, uimm, imm, rs1, rs2, rd, wr, br, ill};
  endfunction

  function automatic logic [60:0] act_word();
    return {bus.out_alu_op, bus.out_shamt, bus.out_shamt_reg, bus.out_use_imm,
            bus.out_imm, bus.out_rs1, bus.out_rs2, bus.out_rd,
            bus.out_reg_write, bus.out_is_branch, bus.out_illegal};
  endfunction

  task automatic add_rule(input logic [31:0] mask, input logic [31:0] match, input int op,
                          input int fmt, input bit wr, input bit sreg, input bit shimm);
    rule_t r;
    r.mask = mask; r.match = match; r.op = op; r.fmt = fmt;
    r.wr = wr; r.sreg = sreg; r.shimm = shimm;
    rules.push_back(r);
  endtask

  // Supported instructions as ISA mask/match patterns; anything unmatched is illegal.
  task automatic build_rules();
    add_rule(32'hFE00707F, 32'h00000033, 0,  FMT_R, 1, 0, 0); // add
    add_rule(32'hFE00707F, 32'h40000033, 1,  FMT_R, 1, 0, 0); // sub
    add_rule(32'hFE00707F, 32'h00001033, 2,  FMT_R, 1, 1, 0); // sll
    add_rule(32'hFE00707F, 32'h00002033, 13, FMT_R, 1, 0, 0); // slt
    add_rule(32'hFE00707F, 32'h00004033, 6,  FMT_R, 1, 0, 0); // xor
    add_rule(32'hFE00707F, 32'h00005033, 4,  FMT_R, 1, 1, 0); // srl
    add_rule(32'hFE00707F, 32'h40005033, 5,  FMT_R, 1, 1, 0); // sra
    add_rule(32'hFE00707F, 32'h00006033, 7,  FMT_R, 1, 0, 0); // or
    add_rule(32'hFE00707F, 32'h00007033, 8,  FMT_R, 1, 0, 0); // and
    add_rule(32'h0000707F, 32'h00000013, 0,  FMT_I, 1, 0, 0); // addi
    add_rule(32'h0000707F, 32'h00002013, 13, FMT_I, 1, 0, 0); // slti
    add_rule(32'h0000707F, 32'h00004013, 6,  FMT_I, 1, 0, 0); // xori
    add_rule(32'h0000707F, 32'h00006013, 7,  FMT_I, 1, 0, 0); // ori
    add_rule(32'h0000707F, 32'h00007013, 8,  FMT_I, 1, 0, 0); // andi
    add_rule(32'hFE00707F, 32'h00001013, 2,  FMT_I, 1, 0, 1); // slli
    add_rule(32'hFE00707F, 32'h00005013, 4,  FMT_I, 1, 0, 1); // srli
    add_rule(32'hFE00707F, 32'h40005013, 5,  FMT_I, 1, 0, 1); // srai
    add_rule(32'h0000707F, 32'h00000063, 9,  FMT_B, 0, 0, 0); // beq
    add_rule(32'h0000707F, 32'h00001063, 10, FMT_B, 0, 0, 0); // bne
    add_rule(32'h0000707F, 32'h00004063, 11, FMT_B, 0, 0, 0); // blt
    add_rule(32'h0000707F, 32'h00005063, 12, FMT_B, 0, 0, 0); // bge
    add_rule(32'h0000007F, 32'h00000003, 0,  FMT_I, 1, 0, 0); // load
    add_rule(32'h0000007F, 32'h00000023, 0,  FMT_S, 0, 0, 0); // store
    add_rule(32'h0000007F, 32'h00000037, 0,  FMT_U, 1, 0, 0); // lui
    add_rule(32'h0000007F, 32'h00000017, 0,  FMT_U, 1, 0, 0); // auipc
    add_rule(32'h0000007F, 32'h0000006F, 0,  FMT_J, 1, 0, 0); // jal
    add_rule(32'h0000007F, 32'h00000067, 0,  FMT_I, 1, 0, 0); // jalr
  endtask

  // Reference decode: table lookup, immediates by signed arithmetic.
  function automatic logic [60:0] model_decode(input logic [31:0] w);
    int signed   sw;
    int          hit;
    rule_t       r;
    logic [31:0] imm;
    sw  = $signed(w);
    hit = -1;
    foreach (rules[k]) if (hit < 0 && (w & rules[k].mask) == rules[k].match) hit = k;
    if (hit < 0)
      return pack(4'd0, 5'd0, 1'b0, 1'b0, 32'd0, w[19:15], w[24:20], w[11:7], 1'b0, 1'b0, 1'b1);
    r = rules[hit];
    case (r.fmt)
      FMT_I:   imm = 32'(sw >>> 20);
      FMT_S:   imm = 32'((sw >>> 25) * 32 + int'(w[11:7]));
      FMT_B:   imm = 32'((sw >>> 31) * 4096 + int'(w[7]) * 2048 + int'(w[30:25]) * 32
                         + int'(w[11:8]) * 2);
      FMT_U:   imm = w & 32'hFFFFF000;
      FMT_J:   imm = 32'((sw >>> 31) * 1048576 + int'(w[19:12]) * 4096 + int'(w[20]) * 2048
                         + int'(w[30:21]) * 2);
      default: imm = 32'd0;
    endcase
    return pack(r.op[3:0], r.shimm ? w[24:20] : 5'd0, r.sreg,
                (r.fmt != FMT_R) && (r.fmt != FMT_B), imm,
                w[19:15], w[24:20], w[11:7], r.wr, r.fmt == FMT_B, 1'b0);
  endfunction

  // ---------------- scoreboard / compare ----------------
  always @(negedge clk) begin
    logic [60:0] act;
    logic [60:0] e;
    act = act_word();
    if (model_rst_q) begin
      check("rst_out_valid", 64'(bus.out_valid), 64'(0));
      check("rst_in_ready", 64'(bus.in_ready), 64'(0));
      check("rst_count", 64'(illegal_count), 64'(0));
      check("rst_out_word", 64'(act), 64'(0));
    end else begin
      check("out_valid", 64'(bus.out_valid), 64'(exp_q.size() != 0));
      check("in_ready", 64'(bus.in_ready), 64'(exp_q.size() < 2));
      check("illegal_count", 64'(illegal_count), 64'(model_cnt));
      if (held && bus.out_valid) check("hold_stable", 64'(act), 64'(held_word));
    end
    held = 1'b0;
    if (rst) begin
      exp_q.delete();
      model_cnt   = 0;
      model_rst_q = 1'b1;
    end else begin
      model_rst_q = 1'b0;
      if (flush) begin
        exp_q.delete();
      end else begin
        if (bus.out_valid && bus.out_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_out", 64'(1), 64'(0));
          end else begin
            e = exp_q.pop_front();
            check("out_word", 64'(act), 64'(e));
            if (e[0] && model_cnt < CNT_MAX) model_cnt++;
          end
        end else if (bus.out_valid) begin
          held      = 1'b1;
          held_word = act;
        end
        if (bus.in_valid && bus.in_ready) exp_q.push_back(model_decode(bus.in_instr));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [31:0] w, output int waited);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_instr = w;
    while (!bus.in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) check("send_timeout", 64'(1), 64'(0));
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    waited = n;
  endtask

  task automatic send_w(input logic [31:0] w);
    int d;
    send(w, d);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  logic [31:0] vec [0:21] = '{
    32'h00311093, 32'h0020A423, 32'h123452B7, 32'h008000EF, 32'hFFC12303,
    32'h00209463, 32'h0050B213, 32'h022081B3, 32'h0020C463, 32'h0020E463,
    32'h4020D1B3, 32'h2030D093, 32'h0020A1B3, 32'h0020F1B3, 32'h0020E1B3,
    32'h002091B3, 32'h0020D1B3, 32'h00001517, 32'h000080E7, 32'h00508213,
    32'h00000063, 32'h0020C3B3
  };

  // ---------------- directed sequence ----------------
  initial begin
    int waited;
    build_rules();

    // Pin the model itself against hand-decoded words.
    check("model_add", 64'(model_decode(32'h002081B3)),
          64'(pack(4'd0, 5'd0, 1'b0, 1'b0, 32'd0, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0)));
    check("model_srai", 64'(model_decode(32'h40735293)),
          64'(pack(4'd5, 5'd7, 1'b0, 1'b1, 32'h00000407, 5'd6, 5'd7, 5'd5, 1'b1, 1'b0, 1'b0)));
    check("model_bge", 64'(model_decode(32'hFE20DCE3)),
          64'(pack(4'd12, 5'd0, 1'b0, 1'b0, 32'hFFFFFFF8, 5'd1, 5'd2, 5'd25, 1'b0, 1'b1, 1'b0)));
    check("model_zero", 64'(model_decode(32'h00000000)),
          64'(pack(4'd0, 5'd0, 1'b0, 1'b0, 32'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1)));

    bus.in_valid  = 1'b0;
    bus.in_instr  = 32'd0;
    bus.out_ready = 1'b1;
    idle(2);
    check("lit_rst_in_ready", 64'(bus.in_ready), 64'(0));
    rst = 1'b0;
    idle(1);
    check("lit_in_ready_after_rst", 64'(bus.in_ready), 64'(1));

    // add x3,x1,x2
    send_w(32'h002081B3);
    check("lit_add_valid", 64'(bus.out_valid), 64'(1));
    check("lit_add_op", 64'(bus.out_alu_op), 64'(0));
    check("lit_add_rd", 64'(bus.out_rd), 64'(3));
    check("lit_add_rs1", 64'(bus.out_rs1), 64'(1));
    check("lit_add_rs2", 64'(bus.out_rs2), 64'(2));
    check("lit_add_wr", 64'(bus.out_reg_write), 64'(1));
    check("lit_add_uimm", 64'(bus.out_use_imm), 64'(0));

    // sub then srai back-to-back
    send_w(32'h402081B3);
    check("lit_sub_op", 64'(bus.out_alu_op), 64'(1));
    send(32'h40735293, waited);
    check("lit_no_bubble", 64'(waited), 64'(0));
    check("lit_srai_op", 64'(bus.out_alu_op), 64'(5));
    check("lit_srai_shamt", 64'(bus.out_shamt), 64'(7));
    check("lit_srai_uimm", 64'(bus.out_use_imm), 64'(1));
    check("lit_srai_rd", 64'(bus.out_rd), 64'(5));
    check("lit_srai_rs1", 64'(bus.out_rs1), 64'(6));

    // bge x1,x2,-8
    send_w(32'hFE20DCE3);
    check("lit_bge_op", 64'(bus.out_alu_op), 64'(12));
    check("lit_bge_imm", 64'(bus.out_imm), 64'(32'hFFFFFFF8));
    check("lit_bge_br", 64'(bus.out_is_branch), 64'(1));
    check("lit_bge_wr", 64'(bus.out_reg_write), 64'(0));
    idle(2);

    // Stall: first word held, second in skid, third refused.
    bus.out_ready = 1'b0;
    send_w(32'h002081B3);
    send_w(32'h00508213);
    bus.in_valid = 1'b1;
    bus.in_instr = 32'h0020C3B3;
    check("lit_stall_in_ready", 64'(bus.in_ready), 64'(0));
    repeat (3) begin
      idle(1);
      check("lit_stall_rd", 64'(bus.out_rd), 64'(3));
      check("lit_stall_in_ready_held", 64'(bus.in_ready), 64'(0));
    end
    bus.out_ready = 1'b1;
    send_w(32'h0020C3B3);
    idle(4);

    // Illegal words and flush.
    send_w(32'h00000000);
    send_w(32'h0020B1B3);
    idle(2);
    check("lit_illegal_count2", 64'(illegal_count), 64'(2));
    bus.out_ready = 1'b0;
    send_w(32'h00000000);
    flush = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_instr = 32'h002081B3;
    idle(1);
    flush = 1'b0;
    bus.in_valid = 1'b0;
    check("lit_flush_valid", 64'(bus.out_valid), 64'(0));
    check("lit_flush_count", 64'(illegal_count), 64'(2));
    check("lit_flush_in_ready", 64'(bus.in_ready), 64'(1));
    idle(1);
    check("lit_flush_discard", 64'(bus.out_valid), 64'(0));
    bus.out_ready = 1'b1;

    // Mixed table with periodic consumer stalls.
    for (int i = 0; i < 22; i++) begin
      bus.out_ready = (i % 4 != 3);
      send_w(vec[i]);
    end
    bus.out_ready = 1'b1;
    idle(4);

    // Counter saturation.
    for (int i = 0; i < 9; i++) send_w(32'h00000000);
    idle(3);
    check("lit_count_sat", 64'(illegal_count), 64'(CNT_MAX));

    // Reset mid-stream with skid full.
    bus.out_ready = 1'b0;
    send_w(32'h002081B3);
    send_w(32'h402081B3);
    rst = 1'b1;
    idle(1);
    check("lit_mid_rst_valid", 64'(bus.out_valid), 64'(0));
    check("lit_mid_rst_in_ready", 64'(bus.in_ready), 64'(0));
    check("lit_mid_rst_count", 64'(illegal_count), 64'(0));
    rst = 1'b0;
    idle(1);
    check("lit_after_rst_in_ready", 64'(bus.in_ready), 64'(1));
    bus.out_ready = 1'b1;
    send_w(32'h00311093);
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
